// File: rtl/piezo_note_decoder_pkg.sv
// Note table, note index encoding and 7-segment letters shared by the piezo tone generator
// and the piezo_note_decoder receive side.
package piezo_note_decoder_pkg;

    localparam int HALF_W    = 12;
    localparam int NUM_NOTES = 8;

    localparam logic [HALF_W-1:0] NOTE_HALF_C2 = 12'd1913;
    localparam logic [HALF_W-1:0] NOTE_HALF_D2 = 12'd1704;
    localparam logic [HALF_W-1:0] NOTE_HALF_E2 = 12'd1518;
    localparam logic [HALF_W-1:0] NOTE_HALF_F2 = 12'd1432;
    localparam logic [HALF_W-1:0] NOTE_HALF_G2 = 12'd1276;
    localparam logic [HALF_W-1:0] NOTE_HALF_A2 = 12'd1137;
    localparam logic [HALF_W-1:0] NOTE_HALF_B2 = 12'd1013;
    localparam logic [HALF_W-1:0] NOTE_HALF_C3 = 12'd956;

    localparam logic [HALF_W-1:0] NOTE_HALF [NUM_NOTES] = '{
        NOTE_HALF_C2, NOTE_HALF_D2, NOTE_HALF_E2, NOTE_HALF_F2,
        NOTE_HALF_G2, NOTE_HALF_A2, NOTE_HALF_B2, NOTE_HALF_C3
    };

    // Index order matches keypad btn[7:0]; NOTE_NONE marks an unclassified half-period.
    typedef enum logic [3:0] {
        NOTE_C2   = 4'd0,
        NOTE_D2   = 4'd1,
        NOTE_E2   = 4'd2,
        NOTE_F2   = 4'd3,
        NOTE_G2   = 4'd4,
        NOTE_A2   = 4'd5,
        NOTE_B2   = 4'd6,
        NOTE_C3   = 4'd7,
        NOTE_NONE = 4'd8
    } note_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } dec_state_t;

    // Segment bit order g..a (bit0 = a), active-high.
    localparam logic [6:0] SEG_LTR_C = 7'h39;
    localparam logic [6:0] SEG_LTR_D = 7'h5E;
    localparam logic [6:0] SEG_LTR_E = 7'h79;
    localparam logic [6:0] SEG_LTR_F = 7'h71;
    localparam logic [6:0] SEG_LTR_G = 7'h3D;
    localparam logic [6:0] SEG_LTR_A = 7'h77;
    localparam logic [6:0] SEG_LTR_B = 7'h7C;

    function automatic logic [7:0] note_onehot(input note_idx_t idx);
        if (idx == NOTE_NONE) return 8'h00;
        return 8'h01 << idx;
    endfunction

    function automatic logic [6:0] note_seg(input logic [7:0] onehot);
        case (onehot)
            8'h01:   return SEG_LTR_C;
            8'h02:   return SEG_LTR_D;
            8'h04:   return SEG_LTR_E;
            8'h08:   return SEG_LTR_F;
            8'h10:   return SEG_LTR_G;
            8'h20:   return SEG_LTR_A;
            8'h40:   return SEG_LTR_B;
            8'h80:   return SEG_LTR_C;
            default: return 7'h00;
        endcase
    endfunction

endpackage

// File: rtl/piezo_note_decoder_if.sv
// Tone input and locked-note outputs of piezo_note_decoder.
// The seg field exists only when TONE_SEG_EN is defined.
interface piezo_note_decoder_if;

    logic       tone_in;
    logic [7:0] note;
    logic       note_valid;
    logic       note_chg;
`ifdef TONE_SEG_EN
    logic [6:0] seg;

    modport slave  (input tone_in, output note, output note_valid, output note_chg, output seg);
    modport master (output tone_in, input note, input note_valid, input note_chg, input seg);
`else
    modport slave  (input tone_in, output note, output note_valid, output note_chg);
    modport master (output tone_in, input note, input note_valid, input note_chg);
`endif

endinterface

// File: rtl/piezo_note_decoder_tone_period_meter.sv
// Synchronizes tone_in, detects either edge and measures the half-period with a
// 12-bit saturating counter; all outputs are registered strobes/values.
module tone_period_meter
    import piezo_note_decoder_pkg::*;
#(
    parameter int TIMEOUT = 4000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tone_in,
    output logic              edge_stb,
    output logic [HALF_W-1:0] half_period,
    output logic              timeout_stb
);

    localparam logic [HALF_W-1:0] TMO_V   = HALF_W'(TIMEOUT);
    localparam logic [HALF_W-1:0] CNT_MAX = '1;

    logic              tone_p0;
    logic              tone_p1;
    logic              tone_p2;
    logic [HALF_W-1:0] cnt;
    logic              edge_c;

    assign edge_c = tone_p1 ^ tone_p2;

    // Stage p0/p1: synchronizer; p2: edge-detect history; counter and strobes follow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tone_p0     <= 1'b0;
            tone_p1     <= 1'b0;
            tone_p2     <= 1'b0;
            cnt         <= '0;
            edge_stb    <= 1'b0;
            timeout_stb <= 1'b0;
            half_period <= '0;
        end else begin
            tone_p0     <= tone_in;
            tone_p1     <= tone_p0;
            tone_p2     <= tone_p1;
            edge_stb    <= edge_c;
            timeout_stb <= (cnt == TMO_V);
            if (edge_c) begin
                half_period <= cnt;
                cnt         <= HALF_W'(1);
            end else if (cnt != CNT_MAX) begin
                cnt <= cnt + HALF_W'(1);
            end
        end
    end

endmodule

// File: rtl/piezo_note_decoder.sv
// Classifies measured tone half-periods against the C2..C3 table and locks onto a note.
// Optional macro TONE_SEG_EN adds the note-letter 7-segment output.
module piezo_note_decoder
    import piezo_note_decoder_pkg::*;
#(
    parameter int TOL      = 16,
    parameter int LOCK_CNT = 4,
    parameter int TIMEOUT  = 4000
) (
    input logic                 clk,
    input logic                 rst,
    piezo_note_decoder_if.slave bus
);

    localparam int                       CNT_W  = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0]         LOCK_V = CNT_W'(LOCK_CNT);
    localparam logic signed [HALF_W:0]   TOL_S  = (HALF_W + 1)'(TOL);

    logic              edge_stb;
    logic              timeout_stb;
    logic [HALF_W-1:0] half_period;

    dec_state_t        state;
    note_idx_t         cand;
    note_idx_t         cls;
    logic [CNT_W-1:0]  match_cnt;
    logic [CNT_W-1:0]  acq_cnt;
    logic [7:0]        note_r;
    logic              valid_r;
    logic              chg_r;

    tone_period_meter #(
        .TIMEOUT (TIMEOUT)
    ) u_meter (
        .clk         (clk),
        .rst         (rst),
        .tone_in     (bus.tone_in),
        .edge_stb    (edge_stb),
        .half_period (half_period),
        .timeout_stb (timeout_stb)
    );

    function automatic note_idx_t classify(input logic [HALF_W-1:0] h);
        logic signed [HALF_W:0] diff;
        classify = NOTE_NONE;
        for (int k = 0; k < NUM_NOTES; k++) begin
            diff = $signed({1'b0, h}) - $signed({1'b0, NOTE_HALF[k]});
            if (diff <= TOL_S && diff >= -TOL_S) classify = note_idx_t'(k);
        end
    endfunction

    // Run length the acquisition counter takes if this edge is accepted.
    always_comb begin
        cls     = classify(half_period);
        acq_cnt = '0;
        if (cls == NOTE_NONE)  acq_cnt = '0;
        else if (cls == cand)  acq_cnt = match_cnt + CNT_W'(1);
        else                   acq_cnt = CNT_W'(1);
    end

    // Stage p3: lock FSM and registered note outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cand      <= NOTE_NONE;
            match_cnt <= '0;
            note_r    <= '0;
            valid_r   <= 1'b0;
            chg_r     <= 1'b0;
        end else begin
            chg_r <= 1'b0;
            if (timeout_stb) begin
                // A coincident edge is the partial first half-period of a new tone.
                state     <= edge_stb ? ST_ACQ : ST_IDLE;
                cand      <= NOTE_NONE;
                match_cnt <= '0;
                note_r    <= '0;
                valid_r   <= 1'b0;
            end else if (edge_stb) begin
                case (state)
                    ST_IDLE: begin
                        state     <= ST_ACQ;
                        cand      <= NOTE_NONE;
                        match_cnt <= '0;
                    end
                    ST_ACQ: begin
                        if (cls != NOTE_NONE) cand <= cls;
                        match_cnt <= acq_cnt;
                        if (acq_cnt >= LOCK_V) begin
                            state   <= ST_LOCKED;
                            note_r  <= note_onehot(cls);
                            valid_r <= 1'b1;
                            chg_r   <= 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (cls != cand) begin
                            state     <= ST_ACQ;
                            note_r    <= '0;
                            valid_r   <= 1'b0;
                            match_cnt <= acq_cnt;
                            if (cls != NOTE_NONE) cand <= cls;
                        end
                    end
                    default: begin
                        state     <= ST_IDLE;
                        match_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.note       = note_r;
    assign bus.note_valid = valid_r;
    assign bus.note_chg   = chg_r;
`ifdef TONE_SEG_EN
    assign bus.seg        = note_seg(note_r);
`endif

endmodule

// File: tb/tb_piezo_note_decoder.sv
// Scoreboard bench for piezo_note_decoder: a note-history reference model predicts lock
// changes, a negedge monitor compares every output change. Honours TONE_SEG_EN.
module tb_piezo_note_decoder;

    localparam int TOL  = 16;
    localparam int LOCK = 4;
    localparam int TMO  = 4000;

    int nom [8] = '{1913, 1704, 1518, 1432, 1276, 1137, 1013, 956};

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic tone = 1'b0;

    int checks = 0;
    int errors = 0;
    int gap    = 0;

    logic [7:0] exp_q [$];
    int         hist  [$];
    bit         started    = 1'b0;
    logic [7:0] model_note = 8'h00;
    logic [7:0] prev_note  = 8'h00;

    piezo_note_decoder_if bus ();
    assign bus.tone_in = tone;

    piezo_note_decoder #(
        .TOL      (TOL),
        .LOCK_CNT (LOCK),
        .TIMEOUT  (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, req, $time);
        end
    endtask

    function automatic int classify(input int h);
        for (int k = 0; k < 8; k++) begin
            if ((h > nom[k] ? h - nom[k] : nom[k] - h) <= TOL) return k;
        end
        return 8;
    endfunction

    function automatic logic [6:0] seg_exp(input logic [7:0] n);
        case (n)
            8'h01: return 7'h39;
            8'h02: return 7'h5E;
            8'h04: return 7'h79;
            8'h08: return 7'h71;
            8'h10: return 7'h3D;
            8'h20: return 7'h77;
            8'h40: return 7'h7C;
            8'h80: return 7'h39;
            default: return 7'h00;
        endcase
    endfunction

    task automatic set_model(input logic [7:0] nn);
        if (nn !== model_note) begin
            exp_q.push_back(nn);
            model_note = nn;
        end
    endtask

    // Locked iff the last LOCK accepted half-periods all fall on the same note.
    task automatic play(input int h);
        bit         same;
        logic [7:0] nn;
        repeat (h - gap) @(negedge clk);
        gap  = 0;
        tone = ~tone;
        if (!started) begin
            started = 1'b1;
        end else begin
            hist.push_back(classify(h));
            if (hist.size() > LOCK) void'(hist.pop_front());
        end
        nn = 8'h00;
        if (hist.size() == LOCK && hist[0] != 8) begin
            same = 1'b1;
            foreach (hist[i]) if (hist[i] != hist[0]) same = 1'b0;
            if (same) nn = 8'd1 << hist[0];
        end
        set_model(nn);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        gap += n;
    endtask

    task automatic forget();
        started = 1'b0;
        hist.delete();
        set_model(8'h00);
    endtask

    function automatic int jit();
        return int'($urandom_range(0, 2 * TOL)) - TOL;
    endfunction

    always @(negedge clk) begin
        check("note_valid", bus.note_valid, bus.note != 8'h00);
        check("note_chg", bus.note_chg, (bus.note != 8'h00) && (bus.note != prev_note));
`ifdef TONE_SEG_EN
        check("seg", bus.seg, seg_exp(bus.note));
`endif
        if (bus.note !== prev_note) begin
            if (exp_q.size() == 0) check("note_unexpected", bus.note, prev_note);
            else                   check("note", bus.note, exp_q.pop_front());
        end
        prev_note = bus.note;
    end

    initial begin
        #2 rst = 1'b0;
        #1;
        check("rst_note", bus.note, 8'h00);
        check("rst_valid", bus.note_valid, 1'b0);
        check("rst_chg", bus.note_chg, 1'b0);
`ifdef TONE_SEG_EN
        check("rst_seg", bus.seg, 7'h00);
`endif
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // C2 lock after one discarded and four measured half-periods
        repeat (5) play(1913);
        idle(4);
        check("c2_lock", bus.note, 8'h01);
        check("c2_valid", bus.note_valid, 1'b1);

        // C3 then A2
        repeat (4) play(956);
        idle(4);
        check("c3_lock", bus.note, 8'h80);
        repeat (4) play(1137);
        idle(4);
        check("a2_lock", bus.note, 8'h20);

        // Tolerance edges around C2
        repeat (4) play(1929);
        idle(4);
        check("tol_hi_in", bus.note, 8'h01);
        repeat (4) play(1930);
        idle(4);
        check("tol_hi_out", bus.note, 8'h00);
        repeat (4) play(1897);
        idle(4);
        check("tol_lo_in", bus.note, 8'h01);
        repeat (4) play(1896);
        idle(4);
        check("tol_lo_out", bus.note, 8'h00);

        // E2 lock then silence
        repeat (4) play(1518);
        idle(4);
        check("e2_lock", bus.note, 8'h04);
        idle(TMO - 10);
        check("e2_hold", bus.note, 8'h04);
        forget();
        idle(30);
        check("timeout_note", bus.note, 8'h00);
        check("timeout_valid", bus.note_valid, 1'b0);
        idle(500);

        // Alternating F2/E2 never locks; stray NONE inside a G2 stream
        play(1432);
        for (int i = 0; i < 4; i++) play((i % 2 == 0) ? 1518 : 1432);
        idle(4);
        check("alt_nolock", bus.note, 8'h00);
        repeat (4) play(1276 + jit());
        idle(4);
        check("g2_lock", bus.note, 8'h10);
        play(700);
        idle(4);
        check("stray_unlock", bus.note, 8'h00);
        repeat (4) play(1276 + jit());
        idle(4);
        check("g2_relock", bus.note, 8'h10);

        // Reset while locked on C3
        repeat (4) play(956);
        idle(4);
        check("c3_relock", bus.note, 8'h80);
`ifdef TONE_SEG_EN
        check("seg_c3", bus.seg, 7'h39);
`endif
        idle(300);
        forget();
        #2 rst = 1'b0;
        #1;
        check("midrst_note", bus.note, 8'h00);
        check("midrst_valid", bus.note_valid, 1'b0);
        check("midrst_chg", bus.note_chg, 1'b0);
        tone = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        gap = 0;

        // Random B2/C3 stream, offsets straddling the tolerance window
        for (int i = 0; i < 7; i++) begin
            int k;
            k = int'($urandom_range(6, 7));
            play(nom[k] + int'($urandom_range(0, 40)) - 20);
        end

        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        check("scoreboard_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
